// File: rtl/rtc_reader_pkg.sv
// Shared constants, state encodings and helpers for the RTC frame reader.
// Register map, strobe decoding and BCD field validation.
package rtc_reader_pkg;

  localparam int T_PHASE_DEF = 10;
  localparam int FRAME_LEN   = 9;

  localparam logic [7:0] A_SEG   = 8'h21;
  localparam logic [7:0] A_MIN   = 8'h22;
  localparam logic [7:0] A_HORA  = 8'h23;
  localparam logic [7:0] A_DIA   = 8'h24;
  localparam logic [7:0] A_MES   = 8'h25;
  localparam logic [7:0] A_ANO   = 8'h26;
  localparam logic [7:0] A_SEGT  = 8'h41;
  localparam logic [7:0] A_MINT  = 8'h42;
  localparam logic [7:0] A_HORAT = 8'h43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2,
    S_COMMIT
  } st_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RUN,
    F_COMMIT
  } frm_e;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_n;
    logic oe;
  } strb_t;

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = A_SEG;
      4'd1:    a = A_MIN;
      4'd2:    a = A_HORA;
      4'd3:    a = A_DIA;
      4'd4:    a = A_MES;
      4'd5:    a = A_ANO;
      4'd6:    a = A_SEGT;
      4'd7:    a = A_MINT;
      4'd8:    a = A_HORAT;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Only ADDR and DATA pull any strobe low; every other state parks the bus.
  function automatic strb_t strb(input st_e s);
    strb_t r;
    r.cs_n = 1'b1;
    r.rd_n = 1'b1;
    r.wr_n = 1'b1;
    r.ad_n = 1'b1;
    r.oe   = 1'b0;
    case (s)
      S_ADDR: begin
        r.cs_n = 1'b0;
        r.wr_n = 1'b0;
        r.ad_n = 1'b0;
        r.oe   = 1'b1;
      end
      S_DATA: begin
        r.cs_n = 1'b0;
        r.rd_n = 1'b0;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One RTC bus transaction: address write then data read (ADDR..GAP2).
// Re-arms directly from the last GAP2 cycle so reads run back to back.
module rtc_bus_cycle
  import rtc_reader_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_ad_in,
  output logic [7:0] o_ad_out,
  output strb_t      o_strb,
  output logic [7:0] o_data,
  output logic       o_done
);

  localparam logic [7:0] RLD = 8'(T_PHASE - 1);

  st_e        r_st;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic [7:0] r_ad_out;
  strb_t      r_strb;
  logic       w_last;

  assign w_last   = (r_cnt == 8'd0);
  assign o_done   = (r_st == S_GAP2) && w_last;
  assign o_ad_out = r_ad_out;
  assign o_strb   = r_strb;
  assign o_data   = r_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_st     <= S_IDLE;
      r_cnt    <= 8'd0;
      r_data   <= 8'h00;
      r_ad_out <= 8'h00;
      r_strb   <= strb(S_IDLE);
    end else if (r_st == S_IDLE || o_done) begin
      if (i_start) begin
        r_st     <= S_ADDR;
        r_cnt    <= RLD;
        r_ad_out <= i_addr;
        r_strb   <= strb(S_ADDR);
      end else if (o_done) begin
        r_st     <= S_IDLE;
        r_cnt    <= 8'd0;
        r_ad_out <= 8'h00;
        r_strb   <= strb(S_IDLE);
      end
    end else if (!w_last) begin
      r_cnt <= r_cnt - 8'd1;
    end else begin
      r_cnt    <= RLD;
      r_ad_out <= 8'h00;
      case (r_st)
        S_ADDR: begin
          r_st   <= S_GAP1;
          r_strb <= strb(S_GAP1);
        end
        S_GAP1: begin
          r_st   <= S_DATA;
          r_strb <= strb(S_DATA);
        end
        S_DATA: begin
          r_data <= i_ad_in;
          r_st   <= S_GAP2;
          r_strb <= strb(S_GAP2);
        end
        default: begin
          r_st   <= S_IDLE;
          r_cnt  <= 8'd0;
          r_strb <= strb(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_reader.sv
// Reads the nine RTC time/timer registers per frame and commits the
// BCD-valid fields to the outputs atomically in a single COMMIT cycle.
module rtc_reader
  import rtc_reader_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] AD_IN,
  output logic [7:0] AD_OUT,
  output logic       AD_OE,
  output logic       CS_N,
  output logic       RD_N,
  output logic       WR_N,
  output logic       AD_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       BCD_ERR,
  output logic [7:0] ANO,
  output logic [7:0] MES,
  output logic [7:0] DIA,
  output logic [7:0] HORA,
  output logic [7:0] MIN,
  output logic [7:0] SEG,
  output logic [7:0] HORAT,
  output logic [7:0] MINT,
  output logic [7:0] SEGT,
  output logic       ALARMA
);

  frm_e       r_st;
  logic [3:0] r_idx;
  logic [7:0] r_shd [FRAME_LEN];
  logic [7:0] r_out [FRAME_LEN];
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_alarma;

  logic       w_cyc_done;
  logic [7:0] w_data;
  logic       w_last_reg;
  logic       w_bus_start;
  logic [3:0] w_idx_nxt;
  logic [7:0] w_addr;
  strb_t      w_strb;
  logic [7:0] w_fld [FRAME_LEN];
  logic [7:0] w_new [FRAME_LEN];
  logic       w_bad;

  assign w_last_reg  = (r_idx == 4'(FRAME_LEN - 1));
  assign w_idx_nxt   = (r_st == F_IDLE) ? 4'd0 : r_idx + 4'd1;
  assign w_addr      = reg_addr(w_idx_nxt);
  assign w_bus_start = (r_st == F_IDLE && START) ||
                       (r_st == F_RUN && w_cyc_done && !w_last_reg);

  rtc_bus_cycle #(
    .T_PHASE (T_PHASE)
  ) u_bus (
    .CLK      (CLK),
    .RST      (RST),
    .i_start  (w_bus_start),
    .i_addr   (w_addr),
    .i_ad_in  (AD_IN),
    .o_ad_out (AD_OUT),
    .o_strb   (w_strb),
    .o_data   (w_data),
    .o_done   (w_cyc_done)
  );

  // Last field bypasses its shadow so the commit lands on the final GAP2 edge.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) begin
      w_fld[i] = r_shd[i];
    end
    w_fld[FRAME_LEN-1] = w_data;
    w_bad = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      w_new[i] = r_out[i];
      if (bcd_ok(w_fld[i])) begin
        w_new[i] = w_fld[i];
      end else begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_st     <= F_IDLE;
      r_idx    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_alarma <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_shd[i] <= 8'h00;
        r_out[i] <= 8'h00;
      end
    end else begin
      case (r_st)
        F_IDLE: begin
          if (START) begin
            r_st   <= F_RUN;
            r_idx  <= 4'd0;
            r_busy <= 1'b1;
          end
        end
        F_RUN: begin
          if (w_cyc_done) begin
            r_shd[r_idx] <= w_data;
            if (w_last_reg) begin
              r_st     <= F_COMMIT;
              r_done   <= 1'b1;
              r_err    <= w_bad;
              r_out    <= w_new;
              r_alarma <= (w_new[6] | w_new[7] | w_new[8]) == 8'h00;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        F_COMMIT: begin
          r_st   <= F_IDLE;
          r_idx  <= 4'd0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        default: begin
          r_st   <= F_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign CS_N    = w_strb.cs_n;
  assign RD_N    = w_strb.rd_n;
  assign WR_N    = w_strb.wr_n;
  assign AD_N    = w_strb.ad_n;
  assign AD_OE   = w_strb.oe;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign BCD_ERR = r_err;
  assign ALARMA  = r_alarma;
  assign SEG     = r_out[0];
  assign MIN     = r_out[1];
  assign HORA    = r_out[2];
  assign DIA     = r_out[3];
  assign MES     = r_out[4];
  assign ANO     = r_out[5];
  assign SEGT    = r_out[6];
  assign MINT    = r_out[7];
  assign HORAT   = r_out[8];

endmodule

// File: tb/tb_rtc_reader.sv
// Bench for rtc_reader: timeline model of the frame plus an RTC bus responder.
// Directed scenarios with literal expectations pin the model.
module tb_rtc_reader;

  localparam int TP = 2;
  localparam int NB = 36 * TP;
  localparam int FC = NB + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] AD_IN;
  logic [7:0] AD_OUT;
  logic       AD_OE, CS_N, RD_N, WR_N, AD_N;
  logic       BUSY, DONE, BCD_ERR, ALARMA;
  logic [7:0] ANO, MES, DIA, HORA, MIN, SEG, HORAT, MINT, SEGT;

  always #5 CLK = ~CLK;

  rtc_reader #(.T_PHASE(TP)) dut (
    .CLK(CLK), .RST(RST), .START(START), .AD_IN(AD_IN),
    .AD_OUT(AD_OUT), .AD_OE(AD_OE), .CS_N(CS_N), .RD_N(RD_N),
    .WR_N(WR_N), .AD_N(AD_N), .BUSY(BUSY), .DONE(DONE),
    .BCD_ERR(BCD_ERR), .ANO(ANO), .MES(MES), .DIA(DIA),
    .HORA(HORA), .MIN(MIN), .SEG(SEG), .HORAT(HORAT),
    .MINT(MINT), .SEGT(SEGT), .ALARMA(ALARMA)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] atab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                           8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] mem [256];
  logic [7:0] lat = 8'h00;

  // RTC device: latch address on write strobe, drive data while RD_N low
  assign AD_IN = !RD_N ? mem[lat] : 8'hEE;
  always @(posedge CLK) begin
    if (!CS_N && !WR_N && !AD_N) lat <= AD_OUT;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  // Model: position within the frame timeline, expected committed fields
  int         fpos = 0;
  logic [7:0] e_out [9];
  logic       e_alarm = 1'b0;
  logic       e_err = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fpos = 0;
      for (int i = 0; i < 9; i++) e_out[i] = 8'h00;
      e_alarm = 1'b0;
      e_err = 1'b0;
    end else begin
      if (fpos == 0) fpos = START ? 1 : 0;
      else if (fpos == FC) fpos = 0;
      else fpos = fpos + 1;
      e_err = 1'b0;
      if (fpos == FC) begin
        for (int i = 0; i < 9; i++) begin
          logic [7:0] v;
          v = mem[atab[i]];
          if (v[7:4] < 4'd10 && v[3:0] < 4'd10) e_out[i] = v;
          else e_err = 1'b1;
        end
        e_alarm = (e_out[6] == 8'h00) && (e_out[7] == 8'h00) &&
                  (e_out[8] == 8'h00);
      end
    end
  end

  always @(negedge CLK) begin : cmp
    int k, r, ph;
    logic [4:0] es;
    logic [7:0] ead;
    logic cad;
    es = 5'b11110;
    ead = 8'h00;
    cad = 1'b1;
    if (fpos >= 1 && fpos <= NB) begin
      k = fpos - 1;
      r = k / (4 * TP);
      ph = (k % (4 * TP)) / TP;
      cad = 1'b0;
      if (ph == 0) begin
        es = 5'b01001;
        ead = atab[r];
        cad = 1'b1;
      end else if (ph == 2) begin
        es = 5'b00110;
      end
    end
    chk("strobes{cs,rd,wr,adn,oe}", {3'b0, CS_N, RD_N, WR_N, AD_N, AD_OE},
        {3'b0, es});
    if (cad) chk("AD_OUT", AD_OUT, ead);
    chk("contention", {7'b0, (AD_OE | ~WR_N) & ~RD_N}, 8'h00);
    chk("cs_without_rw", {7'b0, ~CS_N & RD_N & WR_N}, 8'h00);
    chk("BUSY", {7'b0, BUSY}, {7'b0, fpos != 0});
    chk("DONE", {7'b0, DONE}, {7'b0, fpos == FC});
    chk("BCD_ERR", {7'b0, BCD_ERR}, {7'b0, e_err});
    chk("ALARMA", {7'b0, ALARMA}, {7'b0, e_alarm});
    chk("SEG", SEG, e_out[0]);
    chk("MIN", MIN, e_out[1]);
    chk("HORA", HORA, e_out[2]);
    chk("DIA", DIA, e_out[3]);
    chk("MES", MES, e_out[4]);
    chk("ANO", ANO, e_out[5]);
    chk("SEGT", SEGT, e_out[6]);
    chk("MINT", MINT, e_out[7]);
    chk("HORAT", HORAT, e_out[8]);
  end

  task automatic set_rtc(input logic [7:0] s, input logic [7:0] mi,
                         input logic [7:0] h, input logic [7:0] d,
                         input logic [7:0] me, input logic [7:0] a,
                         input logic [7:0] st, input logic [7:0] mt,
                         input logic [7:0] ht);
    mem[8'h21] = s;  mem[8'h22] = mi; mem[8'h23] = h;
    mem[8'h24] = d;  mem[8'h25] = me; mem[8'h26] = a;
    mem[8'h41] = st; mem[8'h42] = mt; mem[8'h43] = ht;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 4 * FC; i++) begin
      @(negedge CLK);
      if (DONE) begin
        t = cyc;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done: no DONE within %0d cycles", 4 * FC);
  endtask

  task automatic pulse_start(output int s);
    @(negedge CLK);
    s = cyc;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    int s, t, t1, t2, t3, n, tgt;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_SEG", SEG, 8'h00);
    chk("rst_HORAT", HORAT, 8'h00);
    chk("rst_BUSY", {7'b0, BUSY}, 8'h00);
    chk("rst_CS_N", {7'b0, CS_N}, 8'h01);
    RST = 1'b1;
    set_rtc(8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h24, 8'h00, 8'h05, 8'h01);

    // abandon frame during DATA of the 5th register
    pulse_start(s);
    tgt = 4 * (4 * TP) + 2 * TP + 1;
    n = 0;
    while (fpos != tgt && n < 4 * FC) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("midrst_reached", {7'b0, fpos == tgt}, 8'h01);
    chk("midrst_in_data_RD_N", {7'b0, RD_N}, 8'h00);
    chk("midrst_addr_latched", lat, 8'h25);
    RST = 1'b0;
    #1;
    chk("midrst_CS_N", {7'b0, CS_N}, 8'h01);
    chk("midrst_RD_N", {7'b0, RD_N}, 8'h01);
    chk("midrst_AD_OE", {7'b0, AD_OE}, 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    for (int i = 0; i < FC + 10; i++) begin
      @(negedge CLK);
      if (DONE) n++;
    end
    chk("midrst_no_done", n[7:0], 8'h00);
    chk("midrst_SEG", SEG, 8'h00);

    // nominal frame
    pulse_start(s);
    wait_done(t);
    chk("latency", 8'(t - s), 8'd73);
    chk("t1_SEG", SEG, 8'h45);
    chk("t1_MIN", MIN, 8'h30);
    chk("t1_HORA", HORA, 8'h12);
    chk("t1_DIA", DIA, 8'h31);
    chk("t1_MES", MES, 8'h12);
    chk("t1_ANO", ANO, 8'h24);
    chk("t1_MINT", MINT, 8'h05);
    chk("t1_HORAT", HORAT, 8'h01);
    chk("t1_ALARMA", {7'b0, ALARMA}, 8'h00);

    // timer expiry then clear
    set_rtc(8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h24, 8'h00, 8'h00, 8'h00);
    pulse_start(s);
    wait_done(t);
    chk("t2_ALARMA_set", {7'b0, ALARMA}, 8'h01);
    mem[8'h41] = 8'h10;
    pulse_start(s);
    wait_done(t);
    chk("t2_ALARMA_clr", {7'b0, ALARMA}, 8'h00);
    chk("t2_SEGT", SEGT, 8'h10);

    // invalid MIN field
    mem[8'h22] = 8'h7A;
    mem[8'h23] = 8'h13;
    pulse_start(s);
    wait_done(t);
    chk("t3_BCD_ERR", {7'b0, BCD_ERR}, 8'h01);
    chk("t3_MIN_kept", MIN, 8'h30);
    chk("t3_HORA_upd", HORA, 8'h13);
    @(negedge CLK);
    chk("t3_BCD_ERR_pulse", {7'b0, BCD_ERR}, 8'h00);
    mem[8'h22] = 8'h59;

    // START held high: back-to-back frames
    @(negedge CLK);
    START = 1'b1;
    wait_done(t1);
    wait_done(t2);
    wait_done(t3);
    START = 1'b0;
    chk("b2b_space1", 8'(t2 - t1), 8'(NB + 2));
    chk("b2b_space2", 8'(t3 - t2), 8'(NB + 2));
    chk("b2b_MIN", MIN, 8'h59);

    // START pulses while busy are ignored
    repeat (3) @(negedge CLK);
    pulse_start(s);
    n = 0;
    for (int i = 0; i < 2 * FC + 10; i++) begin
      @(negedge CLK);
      if (BUSY && (i % 7) == 3) START = 1'b1;
      else START = 1'b0;
      if (DONE) n++;
    end
    START = 1'b0;
    chk("busy_start_ignored", n[7:0], 8'h01);
    repeat (4) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
